// File: rtl/pmic_sequencer.sv
// pmic_sequencer: power-management sequencer for NUM_RAILS rails.
// Rails are enabled in ascending order and disabled in descending order,
// one rail per STEP_DELAY-cycle step. Each rail's power-good is checked at
// the end of its step. The block also handles low-battery abort, a
// low-power mode (rail 0 only) and a latched power-good fault.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   on           - power request level (1 = up, 0 = down)
//   LB, LP       - low-battery flag, low-power mode request
//   pgood        - per-rail power-good
//   rail_en      - per-rail enable (registered)
//   ready        - all rails up and good (registered)
//   power_led    - OR of rail_en (combinational)
//   battery_led  - latched low-battery indicator (registered)
//   fault        - latched power-good fault (registered)
//   c_state      - current state encoding (registered)
//   T            - one-cycle step-expiry pulse (combinational)
module pmic_sequencer #(
  parameter int unsigned NUM_RAILS  = 3,
  parameter int unsigned CNT_WIDTH  = 28,
  parameter int unsigned STEP_DELAY = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on,
  input  logic                 LB,
  input  logic                 LP,
  input  logic [NUM_RAILS-1:0] pgood,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 ready,
  output logic                 power_led,
  output logic                 battery_led,
  output logic                 fault,
  output logic [2:0]           c_state,
  output logic                 T
);

  localparam int unsigned IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_RAILS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STEP_DELAY - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_LOW_PWR   = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_RAILS-1:0]   r_rail_en, w_rail_en_nxt;
  logic                   r_ready;
  logic                   r_fault;
  logic                   r_battery;
  logic                   w_counting;
  logic                   w_t;
  logic                   w_abort;

  // Step timer runs only while ramping
  assign w_counting = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
  assign w_t        = w_counting && (r_cnt == CNT_LAST);
  assign w_abort    = LB || !on;

  // Next-state, rail index and rail enables
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_rail_en_nxt = r_rail_en;
    case (r_state)
      S_OFF: begin
        w_rail_en_nxt = '0;
        if (on && !LB) begin
          w_state_nxt              = S_RAMP_UP;
          w_idx_nxt                = '0;
          w_rail_en_nxt[w_idx_nxt] = 1'b1;
        end
      end
      S_RAMP_UP: begin
        if (w_t && !pgood[r_idx]) begin
          w_state_nxt = S_FAULT;
        end else if (w_abort) begin
          // Ramp down from the rail currently being brought up
          w_state_nxt = S_RAMP_DOWN;
        end else if (w_t) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_ON;
          end else begin
            w_idx_nxt                = r_idx + IDX_W'(1);
            w_rail_en_nxt[w_idx_nxt] = 1'b1;
          end
        end
      end
      S_ON: begin
        if ((pgood & r_rail_en) != r_rail_en) begin
          w_state_nxt = S_FAULT;
        end else if (w_abort) begin
          w_state_nxt = S_RAMP_DOWN;
          w_idx_nxt   = LAST_IDX;
        end else if (LP) begin
          w_state_nxt   = S_LOW_PWR;
          w_rail_en_nxt = NUM_RAILS'(1);
        end
      end
      S_LOW_PWR: begin
        if (!pgood[0]) begin
          w_state_nxt = S_FAULT;
        end else if (w_abort) begin
          w_state_nxt = S_RAMP_DOWN;
          w_idx_nxt   = '0;
        end else if (!LP) begin
          if (NUM_RAILS == 1) begin
            w_state_nxt = S_ON;
          end else begin
            // Resume the ramp at rail 1; rail 0 is still up
            w_state_nxt              = S_RAMP_UP;
            w_idx_nxt                = IDX_W'(1);
            w_rail_en_nxt[w_idx_nxt] = 1'b1;
          end
        end
      end
      S_RAMP_DOWN: begin
        if (w_t) begin
          w_rail_en_nxt[r_idx] = 1'b0;
          if (r_idx == '0) begin
            w_state_nxt = S_OFF;
          end else begin
            w_idx_nxt = r_idx - IDX_W'(1);
          end
        end
      end
      S_FAULT: begin
        w_rail_en_nxt = '0;
        if (!on) begin
          w_state_nxt = S_OFF;
        end
      end
      default: begin
        w_state_nxt   = S_OFF;
        w_idx_nxt     = '0;
        w_rail_en_nxt = '0;
      end
    endcase
    // All rails drop on the edge that enters FAULT
    if (w_state_nxt == S_FAULT) begin
      w_rail_en_nxt = '0;
    end
  end

  // Counter clears on state entry and on every step
  always_comb begin
    w_cnt_nxt = '0;
    if (w_counting && (w_state_nxt == r_state) && !w_t) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_OFF;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_rail_en <= '0;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_battery <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rail_en <= w_rail_en_nxt;
      r_ready   <= (w_state_nxt == S_ON);
      r_fault   <= (w_state_nxt == S_FAULT);
      if (LB) begin
        r_battery <= 1'b1;
      end else if (r_state == S_OFF) begin
        r_battery <= 1'b0;
      end
    end
  end

  assign rail_en     = r_rail_en;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign battery_led = r_battery;
  assign c_state     = r_state;
  assign power_led   = |r_rail_en;
  assign T           = w_t;

endmodule

// File: tb/tb_pmic_sequencer.sv
// Bench for pmic_sequencer with NUM_RAILS=3, STEP_DELAY=4. pgood follows
// rail_en through a per-vector mask so individual power-goods can be dropped.
module tb_pmic_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       on, LB, LP;
  logic [2:0] pgood, rail_en, c_state, pg_mask;
  logic       ready, power_led, battery_led, fault, T;

  assign pgood = rail_en & pg_mask;

  always #5 clk = ~clk;

  pmic_sequencer #(.NUM_RAILS(3), .CNT_WIDTH(8), .STEP_DELAY(4)) dut (
    .clk(clk), .reset(reset), .on(on), .LB(LB), .LP(LP), .pgood(pgood),
    .rail_en(rail_en), .ready(ready), .power_led(power_led),
    .battery_led(battery_led), .fault(fault), .c_state(c_state), .T(T)
  );

  typedef struct {
    logic       on, lb, lp;
    logic [2:0] mask;
    logic [2:0] rail, st;
    logic       rdy, flt, bat, t;
    int         tag;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic o, lb, lp, input logic [2:0] m, rail, st,
                     input logic rdy, flt, bat, t, input int tag);
    vec_t v;
    v.on = o; v.lb = lb; v.lp = lp; v.mask = m; v.rail = rail; v.st = st;
    v.rdy = rdy; v.flt = flt; v.bat = bat; v.t = t; v.tag = tag;
    vecs.push_back(v);
  endtask

  // Full ramp-up from OFF with on=1: step k is the k-th edge after the request
  task automatic add_ramp_up(input int scn);
    for (int k = 1; k <= 13; k++) begin
      add(1'b1, 1'b0, 1'b0, 3'b111,
          (k < 5) ? 3'b001 : (k < 9) ? 3'b011 : 3'b111,
          (k == 13) ? 3'd2 : 3'd1, k == 13, 1'b0, 1'b0,
          (k % 4 == 0) && (k < 13), scn * 100 + k);
    end
  endtask

  // Ramp-down from all-on; k=0 is the entry edge
  task automatic add_ramp_down(input int scn, input logic o, lb, bat);
    for (int k = 0; k <= 12; k++) begin
      add(o, lb, 1'b0, 3'b111,
          (k < 4) ? 3'b111 : (k < 8) ? 3'b011 : (k < 12) ? 3'b001 : 3'b000,
          (k == 12) ? 3'd0 : 3'd4, 1'b0, 1'b0, bat, (k % 4 == 3),
          scn * 100 + 50 + k);
    end
  endtask

  task automatic chk(input string name, input logic [2:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b", name, got, exp);
    end
  endtask

  // Scoreboard: one expected record per driven vector, popped after the edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      total++;
      if (rail_en !== cur.rail || c_state !== cur.st || ready !== cur.rdy ||
          fault !== cur.flt || battery_led !== cur.bat || T !== cur.t ||
          power_led !== (|cur.rail)) begin
        bad++;
        $display("FAIL vec%0d: got rail=%b st=%0d rdy=%b flt=%b bat=%b T=%b led=%b want rail=%b st=%0d rdy=%b flt=%b bat=%b T=%b led=%b",
                 cur.tag, rail_en, c_state, ready, fault, battery_led, T, power_led,
                 cur.rail, cur.st, cur.rdy, cur.flt, cur.bat, cur.t, |cur.rail);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: power-up, then one cycle in ON
    add_ramp_up(1);
    add(1, 0, 0, 3'b111, 3'b111, 3'd2, 1, 0, 0, 0, 114);
    // 5: low power and return
    add(1, 0, 1, 3'b111, 3'b001, 3'd3, 0, 0, 0, 0, 501);
    add(1, 0, 1, 3'b111, 3'b001, 3'd3, 0, 0, 0, 0, 502);
    for (int k = 1; k <= 9; k++) begin
      add(1'b1, 1'b0, 1'b0, 3'b111, (k < 5) ? 3'b011 : 3'b111,
          (k == 9) ? 3'd2 : 3'd1, k == 9, 1'b0, 1'b0,
          (k % 4 == 0) && (k < 9), 510 + k);
    end
    // 2: power-down
    add_ramp_down(2, 1'b0, 1'b0, 1'b0);
    add(0, 0, 0, 3'b111, 3'b000, 3'd0, 0, 0, 0, 0, 299);
    // 4: low battery from ON; on=1 does not reverse and is ignored in OFF
    add_ramp_up(4);
    add_ramp_down(4, 1'b1, 1'b1, 1'b1);
    add(1, 1, 0, 3'b111, 3'b000, 3'd0, 0, 0, 1, 0, 491);
    add(1, 1, 0, 3'b111, 3'b000, 3'd0, 0, 0, 1, 0, 492);
    add(0, 0, 0, 3'b111, 3'b000, 3'd0, 0, 0, 0, 0, 493);
    // 3: pgood[1] held low -> fault at rail 1's step end
    for (int k = 1; k <= 8; k++) begin
      add(1'b1, 1'b0, 1'b0, 3'b101, (k < 5) ? 3'b001 : 3'b011, 3'd1,
          1'b0, 1'b0, 1'b0, (k % 4 == 0), 300 + k);
    end
    add(1, 0, 0, 3'b101, 3'b000, 3'd5, 0, 1, 0, 0, 309);
    add(1, 0, 0, 3'b101, 3'b000, 3'd5, 0, 1, 0, 0, 310);
    add(1, 0, 0, 3'b101, 3'b000, 3'd5, 0, 1, 0, 0, 311);
    add(0, 0, 0, 3'b101, 3'b000, 3'd0, 0, 0, 0, 0, 312);
    add(0, 0, 0, 3'b111, 3'b000, 3'd0, 0, 0, 0, 0, 313);
    // 6: LB together with pgood[2] loss in ON -> fault wins
    add_ramp_up(6);
    add(1, 1, 0, 3'b011, 3'b000, 3'd5, 0, 1, 1, 0, 601);
    add(0, 0, 0, 3'b111, 3'b000, 3'd0, 0, 0, 1, 0, 602);
    add(0, 0, 0, 3'b111, 3'b000, 3'd0, 0, 0, 0, 0, 603);

    reset = 1'b1; on = 1'b0; LB = 1'b0; LP = 1'b0; pg_mask = 3'b111;
    repeat (2) @(negedge clk);
    chk("reset_rail_en", rail_en, 3'b000);
    chk("reset_state", c_state, 3'd0);
    chk("reset_flags", {ready, fault, battery_led}, 3'b000);
    chk("reset_t_led", {1'b0, T, power_led}, 3'b000);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      #1;
      on = vecs[i].on; LB = vecs[i].lb; LP = vecs[i].lp; pg_mask = vecs[i].mask;
      sb.push_back(vecs[i]);
    end
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    // Reset mid-ramp: rails drop asynchronously, no ramp-down
    #1;
    on = 1'b1; LB = 1'b0; LP = 1'b0; pg_mask = 3'b111;
    repeat (6) @(negedge clk);
    chk("midramp_rail_en", rail_en, 3'b011);
    chk("midramp_state", c_state, 3'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_rail_en", rail_en, 3'b000);
    chk("async_reset_state", c_state, 3'd0);
    chk("async_reset_led", {2'b00, power_led}, 3'b000);
    @(negedge clk);
    on = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_state", c_state, 3'd0);
    chk("post_reset_rail_en", rail_en, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
